// File: rtl/sram_burst_ctrl.sv
// Burst read/write initiator for a single-port 1024x64 SRAM with a 2-entry read response buffer.
// Optional completed-beat counter is built in when SRAM_BURST_CTRL_BEAT_CNT_EN is defined.
module sram_burst_ctrl #(
    parameter int DEPTH = 1024,
    parameter int DW    = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_write,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [AW-1:0] i_cmd_len,
    input  logic          i_wdata_valid,
    output logic          o_wdata_ready,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_wmask,
    output logic          o_rdata_valid,
    input  logic          i_rdata_ready,
    output logic [DW-1:0] o_rdata,
    output logic          o_done,
    output logic [31:0]   o_beat_cnt,
    output logic          o_sram_cen,
    output logic          o_sram_wen,
    output logic [DW-1:0] o_sram_bit_mask,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_wdata,
    input  logic [DW-1:0] i_sram_rdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, remaining_q, addr_hold_q;
    logic          done_q, in_flight_q;
    logic [DW-1:0] fifo_mem [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    fifo_cnt_q;

    logic cmd_ready, wdata_ready, drain_done, accept;
    logic wr_issue, rd_issue, issue, last_beat, drain_empty;
    logic pop, bypass, push, fifo_pop;

    assign last_beat   = (remaining_q == '0);
    assign drain_empty = (fifo_cnt_q == 2'd0) && !in_flight_q;
    assign wr_issue    = (state_q == WRITE) && i_wdata_valid;
    // Reads stall once buffered plus outstanding data would exceed the buffer.
    assign rd_issue    = (state_q == READ) && ((fifo_cnt_q + {1'b0, in_flight_q}) < 2'd2);
    assign issue       = wr_issue || rd_issue;
    assign accept      = i_cmd_valid && cmd_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The drain-complete cycle behaves like IDLE so a new command can be taken alongside o_done.
    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        drain_done  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (i_cmd_valid) state_d = i_cmd_write ? WRITE : READ;
            end
            WRITE: begin
                wdata_ready = 1'b1;
                if (wr_issue && last_beat) state_d = IDLE;
            end
            READ: begin
                if (rd_issue && last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_empty) begin
                    drain_done = 1'b1;
                    cmd_ready  = 1'b1;
                    state_d    = i_cmd_valid ? (i_cmd_write ? WRITE : READ) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            addr_hold_q <= '0;
            done_q      <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            done_q      <= wr_issue && last_beat;
            in_flight_q <= rd_issue;
            if (accept) begin
                addr_q      <= i_cmd_addr;
                remaining_q <= i_cmd_len;
            end else if (issue) begin
                addr_q      <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                remaining_q <= remaining_q - AW'(1);
            end
            if (issue) addr_hold_q <= addr_q;
        end
    end

    // Data returning into an empty buffer goes straight to the consumer when it is ready.
    assign pop      = o_rdata_valid && i_rdata_ready;
    assign bypass   = (fifo_cnt_q == 2'd0) && in_flight_q && pop;
    assign push     = in_flight_q && !bypass;
    assign fifo_pop = pop && (fifo_cnt_q != 2'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= i_sram_rdata;
                wr_ptr_q           <= !wr_ptr_q;
            end
            if (fifo_pop) rd_ptr_q <= !rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    assign o_cmd_ready     = cmd_ready;
    assign o_wdata_ready   = wdata_ready;
    assign o_done          = done_q || drain_done;
    assign o_rdata_valid   = (fifo_cnt_q != 2'd0) || in_flight_q;
    assign o_rdata         = (fifo_cnt_q != 2'd0) ? fifo_mem[rd_ptr_q] :
                             (in_flight_q ? i_sram_rdata : '0);
    assign o_sram_cen      = issue;
    assign o_sram_wen      = wr_issue;
    assign o_sram_bit_mask = wr_issue ? i_wmask : '0;
    assign o_sram_wdata    = wr_issue ? i_wdata : '0;
    assign o_sram_addr     = issue ? addr_q : addr_hold_q;

`ifdef SRAM_BURST_CTRL_BEAT_CNT_EN
    logic [31:0] beat_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_q + {31'd0, wr_issue} + {31'd0, pop};
        end
    end

    assign o_beat_cnt = beat_cnt_q;
`else
    assign o_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: directed bursts plus randomized traffic against a
// word-level shadow memory; a behavioural 1024x64 SRAM sits on the controller's SRAM port.
module tb_sram_burst_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [9:0]  i_cmd_addr;
    logic [9:0]  i_cmd_len;
    logic        i_wdata_valid;
    logic        o_wdata_ready;
    logic [63:0] i_wdata;
    logic [63:0] i_wmask;
    logic        o_rdata_valid;
    logic        i_rdata_ready;
    logic [63:0] o_rdata;
    logic        o_done;
    logic [31:0] o_beat_cnt;
    logic        o_sram_cen;
    logic        o_sram_wen;
    logic [63:0] o_sram_bit_mask;
    logic [9:0]  o_sram_addr;
    logic [63:0] o_sram_wdata;
    logic [63:0] i_sram_rdata;

    sram_burst_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
        .i_wdata(i_wdata), .i_wmask(i_wmask),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
        .o_done(o_done), .o_beat_cnt(o_beat_cnt),
        .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen), .o_sram_bit_mask(o_sram_bit_mask),
        .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural SRAM: bit-masked write, one-cycle read latency.
    bit [63:0] sram_mem [0:1023];
    always @(posedge i_clk) begin
        if (o_sram_cen) begin
            if (o_sram_wen)
                sram_mem[o_sram_addr] <= (sram_mem[o_sram_addr] & ~o_sram_bit_mask) |
                                         (o_sram_wdata & o_sram_bit_mask);
            else
                i_sram_rdata <= sram_mem[o_sram_addr];
        end
    end

    bit [63:0] ref_mem [0:1023];
    bit [63:0] wbeat_data [0:15];
    bit [63:0] wbeat_mask [0:15];
    int        beats_done;
    int        total_checks;
    int        passed_checks;
    int        failed_checks;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) begin
            passed_checks++;
        end else begin
            failed_checks++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] expCnt();
`ifdef SRAM_BURST_CTRL_BEAT_CNT_EN
        return 64'(unsigned'(beats_done));
`else
        return 64'd0;
`endif
    endfunction

    task automatic checkResetOutputs(input string pre);
        checkOutput({pre, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
        checkOutput({pre, "_wdata_ready"}, 64'(o_wdata_ready), 64'd0);
        checkOutput({pre, "_rdata_valid"}, 64'(o_rdata_valid), 64'd0);
        checkOutput({pre, "_rdata"}, o_rdata, 64'd0);
        checkOutput({pre, "_done"}, 64'(o_done), 64'd0);
        checkOutput({pre, "_beat_cnt"}, 64'(o_beat_cnt), 64'd0);
        checkOutput({pre, "_cen"}, 64'(o_sram_cen), 64'd0);
        checkOutput({pre, "_wen"}, 64'(o_sram_wen), 64'd0);
        checkOutput({pre, "_mask"}, o_sram_bit_mask, 64'd0);
        checkOutput({pre, "_addr"}, 64'(o_sram_addr), 64'd0);
        checkOutput({pre, "_wdata"}, o_sram_wdata, 64'd0);
    endtask

    // mode 0: valid/ready held high; mode 1: random; mode 2: read ready low on cycles 3..7.
    task automatic applyStimulus(input bit wr, input logic [9:0] addr, input int len, input int mode);
        int         cyc, beat, issued, popped;
        bit         done_seen;
        logic [9:0] exp_addr;
        @(negedge i_clk);
        i_cmd_valid   = 1'b1;
        i_cmd_write   = wr;
        i_cmd_addr    = addr;
        i_cmd_len     = 10'(len);
        i_wdata_valid = 1'b0;
        i_rdata_ready = 1'b0;
        #1;
        checkOutput("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
        cyc = 0; beat = 0; issued = 0; popped = 0; done_seen = 0;
        if (wr) begin
            while (beat <= len && cyc < 300) begin
                @(negedge i_clk);
                cyc++;
                i_cmd_valid   = 1'b0;
                i_wdata_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                i_wdata       = wbeat_data[beat];
                i_wmask       = wbeat_mask[beat];
                #1;
                checkOutput("wr_wdata_ready", 64'(o_wdata_ready), 64'd1);
                checkOutput("wr_cmd_ready_busy", 64'(o_cmd_ready), 64'd0);
                checkOutput("wr_done_early", 64'(o_done), 64'd0);
                if (i_wdata_valid) begin
                    exp_addr = 10'((int'(addr) + beat) % 1024);
                    checkOutput("wr_cen", 64'(o_sram_cen), 64'd1);
                    checkOutput("wr_wen", 64'(o_sram_wen), 64'd1);
                    checkOutput("wr_addr", 64'(o_sram_addr), 64'(exp_addr));
                    checkOutput("wr_mask", o_sram_bit_mask, wbeat_mask[beat]);
                    checkOutput("wr_data", o_sram_wdata, wbeat_data[beat]);
                    ref_mem[exp_addr] = (ref_mem[exp_addr] & ~wbeat_mask[beat]) |
                                        (wbeat_data[beat] & wbeat_mask[beat]);
                    beat++;
                    beats_done++;
                end else begin
                    checkOutput("wr_gap_cen", 64'(o_sram_cen), 64'd0);
                    checkOutput("wr_gap_mask", o_sram_bit_mask, 64'd0);
                end
            end
            @(negedge i_clk);
            i_wdata_valid = 1'b0;
            #1;
            checkOutput("wr_beats", 64'(beat), 64'(len + 1));
            checkOutput("wr_done", 64'(o_done), 64'd1);
            checkOutput("wr_done_cmd_ready", 64'(o_cmd_ready), 64'd1);
            checkOutput("wr_beat_cnt", 64'(o_beat_cnt), expCnt());
        end else begin
            while (!done_seen && cyc < 600) begin
                @(negedge i_clk);
                cyc++;
                i_cmd_valid = 1'b0;
                case (mode)
                    0:       i_rdata_ready = 1'b1;
                    1:       i_rdata_ready = 1'($urandom_range(0, 1));
                    default: i_rdata_ready = !(cyc >= 3 && cyc < 8);
                endcase
                #1;
                if (o_sram_cen) begin
                    exp_addr = 10'((int'(addr) + issued) % 1024);
                    checkOutput("rd_wen", 64'(o_sram_wen), 64'd0);
                    checkOutput("rd_addr", 64'(o_sram_addr), 64'(exp_addr));
                    if (mode == 0) checkOutput("rd_issue_cycle", 64'(cyc), 64'(issued + 1));
                    issued++;
                    checkOutput("rd_outstanding_le2", 64'(issued - popped <= 2), 64'd1);
                end
                if (o_rdata_valid && i_rdata_ready) begin
                    checkOutput("rd_data", o_rdata, ref_mem[(int'(addr) + popped) % 1024]);
                    if (mode == 0) checkOutput("rd_data_cycle", 64'(cyc), 64'(popped + 2));
                    popped++;
                    beats_done++;
                end
                if (o_done) done_seen = 1'b1;
                else checkOutput("rd_cmd_ready_busy", 64'(o_cmd_ready), 64'd0);
            end
            checkOutput("rd_done_seen", 64'(done_seen), 64'd1);
            checkOutput("rd_issued", 64'(issued), 64'(len + 1));
            checkOutput("rd_popped", 64'(popped), 64'(len + 1));
            if (mode == 0) checkOutput("rd_done_cycle", 64'(cyc), 64'(len + 3));
            checkOutput("rd_done_cmd_ready", 64'(o_cmd_ready), 64'd1);
            checkOutput("rd_beat_cnt", 64'(o_beat_cnt), expCnt());
            i_rdata_ready = 1'b0;
        end
    endtask

    int rst_issued;
    int rst_cyc;
    bit rnd_wr;
    int rnd_len;

    initial begin
        total_checks = 0; passed_checks = 0; failed_checks = 0; beats_done = 0;
        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
        i_wdata_valid = 1'b0; i_wdata = '0; i_wmask = '0; i_rdata_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        checkResetOutputs("rst_init");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        $display("[TB] 4-beat write at 0x010");
        for (int k = 0; k < 4; k++) begin
            wbeat_data[k] = 64'hA0 + 64'(k);
            wbeat_mask[k] = '1;
        end
        applyStimulus(1'b1, 10'h010, 3, 0);

        $display("[TB] 4-beat read at 0x010");
        applyStimulus(1'b0, 10'h010, 3, 0);

        $display("[TB] 8-beat read with consumer stall");
        applyStimulus(1'b0, 10'h010, 7, 2);

        $display("[TB] wrapping write with partial mask, then read back");
        wbeat_data[0] = 64'h1111_1111_1111_1111;
        wbeat_mask[0] = '1;
        applyStimulus(1'b1, 10'h000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            wbeat_data[k] = 64'hCAFE_F00D_5500_0000 + 64'(k);
            wbeat_mask[k] = '1;
        end
        wbeat_mask[2] = 64'h0000_0000_FFFF_FFFF;
        applyStimulus(1'b1, 10'h3FE, 3, 0);
        applyStimulus(1'b0, 10'h3FE, 3, 0);

        $display("[TB] reset during an 8-beat read");
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 10'h020; i_cmd_len = 10'd7;
        #1;
        checkOutput("rst_cmd_accept", 64'(o_cmd_ready), 64'd1);
        rst_issued = 0; rst_cyc = 0;
        while (rst_issued < 3 && rst_cyc < 50) begin
            @(negedge i_clk);
            rst_cyc++;
            i_cmd_valid = 1'b0;
            i_rdata_ready = 1'b1;
            #1;
            if (o_sram_cen) rst_issued++;
        end
        checkOutput("rst_reached_beat2", 64'(rst_issued), 64'd3);
        i_rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        repeat (2) begin
            @(negedge i_clk);
            #1;
            checkOutput("rst_hold_done", 64'(o_done), 64'd0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_rdata_ready = 1'b0;
        beats_done = 0;
        applyStimulus(1'b0, 10'h010, 0, 0);

        $display("[TB] beat counter after fresh reset");
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        beats_done = 0;
        for (int k = 0; k < 4; k++) begin
            wbeat_data[k] = 64'h5A5A_0000_0000_0100 + 64'(k);
            wbeat_mask[k] = '1;
        end
        applyStimulus(1'b1, 10'h100, 3, 0);
        applyStimulus(1'b0, 10'h100, 3, 0);
`ifdef SRAM_BURST_CTRL_BEAT_CNT_EN
        checkOutput("beat_cnt_total", 64'(o_beat_cnt), 64'd8);
`else
        checkOutput("beat_cnt_total", 64'(o_beat_cnt), 64'd0);
`endif

        $display("[TB] randomized bursts");
        for (int n = 0; n < 24; n++) begin
            rnd_wr  = 1'($urandom_range(0, 1));
            rnd_len = int'($urandom_range(0, 12));
            for (int k = 0; k < 16; k++) begin
                wbeat_data[k] = {$urandom(), $urandom()};
                wbeat_mask[k] = ($urandom_range(0, 1) == 1) ? '1 : {$urandom(), $urandom()};
            end
            applyStimulus(rnd_wr, 10'($urandom_range(0, 1023)), rnd_len, 1);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst access controller that acts as the initiator for the 1024x64 local/in-out SRAM wrapper. It accepts single-command read or write bursts from an accelerator datapath, generates per-beat SRAM enable, write, mask, address and data signals, and captures SRAM read data. Read data is returned through a 2-entry backpressure-safe response buffer. The block sits between Octree compute engines and one `sram_1024x64` instance.

## Interface
- `DEPTH`, 1024 — SRAM word count; address width is clog2(DEPTH) = 10.
- `DW`, 64 — data and mask width.
- `i_clk` in 1 — clock; every flop is rising-edge.
- `i_rst_n` in 1 — reset, asynchronous assert, active-low.
- `i_cmd_valid` in 1, `o_cmd_ready` out 1 — command handshake.
- `i_cmd_write` in 1 — 1 = write burst, 0 = read burst.
- `i_cmd_addr` in 10 — start address.
- `i_cmd_len` in 10 — beats minus 1; 0 means 1 beat, 1023 means 1024 beats.
- `i_wdata_valid` in 1, `o_wdata_ready` out 1, `i_wdata` in 64, `i_wmask` in 64 — write beat stream. A mask bit of 1 means that bit is written.
- `o_rdata_valid` out 1, `i_rdata_ready` in 1, `o_rdata` out 64 — read beat stream.
- `o_done` out 1 — one-cycle pulse at burst completion.
- `o_beat_cnt` out 32 — completed-beat counter (see Configuration).
- `o_sram_cen` out 1, `o_sram_wen` out 1, `o_sram_bit_mask` out 64, `o_sram_addr` out 10, `o_sram_wdata` out 64 — SRAM port. All are active-high and combinational from the current state and handshakes.
- `i_sram_rdata` in 64 — SRAM read data, valid the cycle after a read access.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN. Reset state is IDLE.
- IDLE:
  - `o_cmd_ready`=1.
  - On `i_cmd_valid`, latch addr, len and write; clear the beat-remaining counter to len.
  - Go to WRITE or READ.
- WRITE:
  - `o_wdata_ready`=1.
  - Each `i_wdata_valid` cycle issues `o_sram_cen`=1, `o_sram_wen`=1, `o_sram_addr`=current addr, and drives mask and data straight through.
  - Addr increments by 1 and wraps from 1023 to 0.
  - After the last beat, go to IDLE and pulse `o_done` in the next cycle.
- READ:
  - Issue a read beat (`o_sram_cen`=1, `o_sram_wen`=0) only when FIFO occupancy plus in-flight reads is less than 2.
  - The in-flight flag sets on issue and clears the next cycle, when `i_sram_rdata` is pushed into the FIFO.
  - Addr wraps as in WRITE.
  - After the last read issue, go to DRAIN.
- DRAIN:
  - Wait until the in-flight flag is 0 and the FIFO is empty.
  - Then go to IDLE with the `o_done` pulse asserted in that transition cycle.
- Response FIFO:
  - 2 entries; `o_rdata`=head entry; `o_rdata_valid`=not empty.
  - A push and a pop in the same cycle are both honoured, with occupancy unchanged.
  - Read data is never dropped and never duplicated.
- Outside an issuing cycle, the SRAM outputs are `o_sram_cen`=0, `o_sram_wen`=0, mask=0, data=0, and addr holds its last value.
- A command arriving while not in IDLE is not accepted (`o_cmd_ready`=0).
- Reset mid-burst:
  - Immediate return to IDLE, FIFO emptied, in-flight cleared, and no `o_done`.
  - Any read data arriving after reset is discarded.

## Timing
- Reset values: `o_cmd_ready`=1; all other outputs 0; `o_beat_cnt`=0.
- Write: the SRAM write occurs on the same edge as the wdata handshake, with zero-cycle issue latency.
- Read: issue at cycle N, FIFO push at N+1, and `o_rdata_valid` earliest at N+1 (one cycle of data latency).
- Sustained throughput: 1 beat/cycle for reads and writes when `i_rdata_ready` and `i_wdata_valid` are held high.
- A 1-beat read with ready high:
  - Cmd accepted at cycle 0, issue at 1, data valid at 2.
  - `o_done` at 3, where `o_cmd_ready` returns to 1.

## Configuration
- `SRAM_BURST_CTRL_BEAT_CNT_EN` defined:
  - `o_beat_cnt` increments by 1 per completed beat (write issue or read pop).
  - It is 32-bit and wraps at 2^32-1 to 0.
  - It resets only by `i_rst_n`.
- Undefined: the counter logic is absent and `o_beat_cnt` is tied to 0.

## Test plan
- Write len=3 at addr 0x010 with data 0xA0..0xA3 and mask all-ones, wdata valid continuously:
  - Four consecutive SRAM writes to 0x010–0x013.
  - `o_done` one cycle after the 4th beat.
- Read len=3 at 0x010 with `i_rdata_ready`=1:
  - `o_rdata` = 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after the cmd handshake.
  - `o_done` the cycle after the last.
- Read len=7 with `i_rdata_ready` held 0 for 5 cycles mid-burst:
  - At most 2 beats buffered and no further `o_sram_cen` pulses.
  - All 8 beats delivered in order with no loss.
- Write at addr 0x3FE len=3:
  - SRAM addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - Partial mask 0x00000000FFFFFFFF on beat 2 updates only the low half of 0x000.
- Assert `i_rst_n`=0 during beat 2 of an 8-beat read:
  - Outputs return to reset values at once.
  - No `o_done`; a following 1-beat read works normally.
- Run the 4-beat write plus 4-beat read above with the macro defined:
  - `o_beat_cnt`=8.
  - Without the macro, `o_beat_cnt`=0 throughout.
